change_dispenser: RTL and testbench
===================================

# change_dispenser

Payout engine for the vending controller: accepts a change amount in kurus and pays it out as individual coins to the coin hopper over a valid/ack handshake. It uses the same coin encoding as the controller's coin input, running in the opposite direction. It pays greedily, largest coin first, tracks hopper stock, and reports any amount it cannot pay. It sits between the controller's `change` output and the hopper driver.

## Interface
Parameters:
- `AMT_W`, 10, width of amounts in kurus (max 1023)
- `STOCK_W`, 8, width of each coin stock counter
- `INIT_STOCK`, 20, stock count of each denomination after reset
- `ACK_TIMEOUT`, 255, cycles `coin_valid` may wait for `coin_ack` before fault

Ports:
- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `req` in 1: start payout; sampled only in IDLE
- `amount` in AMT_W: change owed, in kurus, captured with `req`
- `coin` out 2: coin being presented; 01 = 50 kurus, 10 = 1 TL, 00 = none (11 is never driven)
- `coin_valid` out 1: `coin` is valid and awaiting hopper drop
- `coin_ack` in 1: hopper confirms drop; ignored unless `coin_valid`
- `busy` out 1: payout in progress (any state except IDLE)
- `done` out 1: one-cycle pulse at payout end
- `short` out 1: `remaining` ≠ 0 at `done`; held until next accepted `req`
- `remaining` out AMT_W: amount still owed
- `fault` out 1: ack timeout; sticky until `rst`
- `refill_50`, `refill_100` in 1: add one coin to the stock of that denomination
- `stock_50`, `stock_100` out STOCK_W: current stock counts

## Operation
- Reset values: `coin`=00, `coin_valid`=0, `busy`=0, `done`=0, `short`=0, `fault`=0, `remaining`=0, stocks=`INIT_STOCK`, state=IDLE.
- States: IDLE, SELECT, PRESENT, DONE, FAULT.
- IDLE: on `req`, latch `remaining`←`amount`, clear `short`, go to SELECT. Any other input is ignored.
- SELECT picks the next coin greedily:
  - If `remaining`≥100 and `stock_100`>0: coin 10, go to PRESENT.
  - Else if `remaining`≥50 and `stock_50`>0: coin 01, go to PRESENT.
  - Else go to DONE.
- PRESENT:
  - `coin_valid`=1, and `coin` holds stable.
  - On `coin_valid & coin_ack`, subtract 100 or 50 from `remaining`, decrement the matching stock, and go to SELECT.
  - Timeout: go to FAULT after ACK_TIMEOUT cycles in PRESENT without ack.
- DONE: `done`=1 for one cycle, `short`←(`remaining`≠0), go to IDLE.
- FAULT: `fault`=1, `coin_valid`=0, `busy`=1. Leaves only on `rst`. `remaining` is frozen at the unpaid amount.
- `req` while busy is ignored; it is neither queued nor latched.
- Arithmetic: `remaining` never underflows, because subtraction occurs only after the ≥ check. A residue not divisible by 50 (e.g. 20) is left in `remaining`, and `short` is set.
- Refill: stock increments saturate at all-ones. A refill and a dispense of the same denomination in one cycle leave the stock unchanged.
- `amount`=0 with `req`: IDLE→SELECT→DONE, `short`=0.
- `rst` mid-payout: immediate return to reset values. The coin in flight is abandoned, and stocks reload to INIT_STOCK.

## Timing
- `req` at cycle N: `busy`=1 at N+1 (SELECT), `coin_valid`=1 at N+2.
- Ack at cycle M: `coin_valid`=0 and `remaining` updated at M+1 (SELECT). The next coin is valid at M+2, so peak rate is one coin per 2 cycles.
- Final ack at M: DONE at M+1 (`done` pulse), `busy`=0 at M+2.
- Timeout: the counter starts at the first PRESENT cycle. With no ack, `fault`=1 on cycle ACK_TIMEOUT+1 of PRESENT.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CHANGE_STOCK_TRACK_EN` defined: stock counters, refill inputs and stock-aware selection work as described above.
- `CHANGE_STOCK_TRACK_EN` undefined:
  - Supply is treated as infinite; SELECT checks only `remaining`.
  - `stock_50`/`stock_100` tie to all-ones, and `refill_*` are ignored.
  - Ports stay present in both builds.

## Structure
- Shared package `vend_pkg` holds:
  - coin codes COIN_NONE=2'b00, COIN_50=2'b01, COIN_100=2'b10
  - coin values 50 and 100 as AMT_W constants
  - the dispenser state enum
- One sub-module, `ack_watchdog`: a loadable down-counter with clear (on entering PRESENT) and an expiry flag.

## Test plan
- Full stock, `amount`=250 → coins 10, 10, 01 with prompt acks; `done` pulse; `remaining`=0, `short`=0; `stock_100`=18, `stock_50`=19.
- `amount`=120 → coin 10, then `done` with `remaining`=20, `short`=1.
- `stock_100` preset to 1, `amount`=250 → coins 10, 01, 01, 01; `stock_100`=0, `remaining`=0.
- `amount`=100 with ack never asserted → `coin_valid` held for ACK_TIMEOUT cycles; then `fault`=1, `coin_valid`=0; a new `req` is ignored until `rst`.
- `rst` asserted while PRESENT holds coin 10 → next cycle all outputs at reset values, stocks=20; a `req` while busy produces no second payout.
- `refill_100` and an ack of coin 10 in the same cycle → `stock_100` unchanged; `refill_50` at 255 stays 255.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, coin values and the change
// dispenser state encoding. Coin codes match the controller's coin input.
// No ports (package).
package vend_pkg;

  localparam int VEND_AMT_W = 10;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;

  localparam logic [VEND_AMT_W-1:0] COIN_VAL_50  = 10'd50;
  localparam logic [VEND_AMT_W-1:0] COIN_VAL_100 = 10'd100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PRESENT,
    ST_DONE,
    ST_FAULT
  } disp_state_t;

endpackage

// File: rtl/ack_watchdog.sv
// Ack watchdog: down-counter reloaded by clr, counts while en, flags expiry.
// Ports: clk/rst (sync, active-high), clr loads TIMEOUT-1, en decrements,
// expired is high once the counter has reached zero (registered count).
module ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Loaded with TIMEOUT-1 so that the TIMEOUT-th waiting cycle sees zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: pays an amount greedily (1 TL before 50 kurus) to the
// hopper one coin at a time over coin_valid/coin_ack, tracking coin stock.
// Ports: req/amount start a payout (IDLE only); coin/coin_valid/coin_ack talk
// to the hopper; busy/done/short/remaining/fault report status; refill_50/100
// and stock_50/100 manage stock. All outputs come straight from flops.
// Build option: CHANGE_STOCK_TRACK_EN enables stock counters and refills;
// without it supply is infinite and stock outputs read all-ones.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = VEND_AMT_W,
  parameter int STOCK_W     = 8,
  parameter int INIT_STOCK  = 20,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [AMT_W-1:0]   amount,
  output logic [1:0]         coin,
  output logic               coin_valid,
  input  logic               coin_ack,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   remaining,
  output logic               fault,
  input  logic               refill_50,
  input  logic               refill_100,
  output logic [STOCK_W-1:0] stock_50,
  output logic [STOCK_W-1:0] stock_100
);

  localparam logic [AMT_W-1:0] V50  = AMT_W'(COIN_VAL_50);
  localparam logic [AMT_W-1:0] V100 = AMT_W'(COIN_VAL_100);

  disp_state_t      state, state_nxt;
  logic [1:0]       coin_q, coin_nxt;
  logic [AMT_W-1:0] rem_q, rem_nxt, rem_after;
  logic             short_q, short_nxt;
  logic             wd_clr, wd_expired;
  logic             ack_fire;

  // Availability now (for SELECT) and after this cycle's stock update
  // (for the look-ahead taken on an ack).
  logic avail50_now, avail100_now, avail50_nxt, avail100_nxt;

  function automatic logic [1:0] pick_coin(input logic [AMT_W-1:0] rem,
                                           input logic has100,
                                           input logic has50);
    if ((rem >= V100) && has100) return COIN_100;
    else if ((rem >= V50) && has50) return COIN_50;
    else return COIN_NONE;
  endfunction

  assign ack_fire  = (state == ST_PRESENT) && coin_ack;
  assign rem_after = (coin_q == COIN_100) ? (rem_q - V100) : (rem_q - V50);

`ifdef CHANGE_STOCK_TRACK_EN
  logic [STOCK_W-1:0] s50_q, s100_q, s50_nxt, s100_nxt;
  logic               dec50, dec100;

  // Refill and dispense of the same denomination cancel out.
  function automatic logic [STOCK_W-1:0] stock_step(input logic [STOCK_W-1:0] cur,
                                                    input logic inc,
                                                    input logic dec);
    stock_step = cur;
    if (inc && !dec && (cur != '1)) stock_step = cur + STOCK_W'(1);
    else if (dec && !inc) stock_step = cur - STOCK_W'(1);
  endfunction

  assign dec50    = ack_fire && (coin_q == COIN_50);
  assign dec100   = ack_fire && (coin_q == COIN_100);
  assign s50_nxt  = stock_step(s50_q, refill_50, dec50);
  assign s100_nxt = stock_step(s100_q, refill_100, dec100);

  always_ff @(posedge clk) begin
    if (rst) begin
      s50_q  <= STOCK_W'(INIT_STOCK);
      s100_q <= STOCK_W'(INIT_STOCK);
    end else begin
      s50_q  <= s50_nxt;
      s100_q <= s100_nxt;
    end
  end

  assign avail50_now  = (s50_q != '0);
  assign avail100_now = (s100_q != '0);
  assign avail50_nxt  = (s50_nxt != '0);
  assign avail100_nxt = (s100_nxt != '0);
  assign stock_50     = s50_q;
  assign stock_100    = s100_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{refill_50, refill_100, STOCK_W'(INIT_STOCK)};
  assign avail50_now  = 1'b1;
  assign avail100_now = 1'b1;
  assign avail50_nxt  = 1'b1;
  assign avail100_nxt = 1'b1;
  assign stock_50     = '1;
  assign stock_100    = '1;
`endif

  ack_watchdog #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (state == ST_PRESENT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      coin_q  <= COIN_NONE;
      rem_q   <= '0;
      short_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      coin_q  <= coin_nxt;
      rem_q   <= rem_nxt;
      short_q <= short_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    coin_nxt  = coin_q;
    rem_nxt   = rem_q;
    short_nxt = short_q;
    wd_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          rem_nxt   = amount;
          short_nxt = 1'b0;
          state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        coin_nxt = pick_coin(rem_q, avail100_now, avail50_now);
        if (coin_nxt != COIN_NONE) begin
          state_nxt = ST_PRESENT;
          wd_clr    = 1'b1;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_PRESENT: begin
        if (coin_ack) begin
          // Look ahead: if no further coin can be paid, skip SELECT so the
          // final ack is followed directly by the done pulse.
          rem_nxt  = rem_after;
          coin_nxt = COIN_NONE;
          if (pick_coin(rem_after, avail100_nxt, avail50_nxt) == COIN_NONE)
            state_nxt = ST_DONE;
          else
            state_nxt = ST_SELECT;
        end else if (wd_expired) begin
          coin_nxt  = COIN_NONE;
          state_nxt = ST_FAULT;
        end
      end
      ST_DONE: begin
        short_nxt = (rem_q != '0);
        state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_IDLE;
        coin_nxt  = COIN_NONE;
      end
    endcase
  end

  assign coin       = coin_q;
  assign coin_valid = (state == ST_PRESENT);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign fault      = (state == ST_FAULT);
  assign short      = short_q;
  assign remaining  = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: reference model pushes expected coins into a
// queue at request time; coins presented by the DUT are popped and compared.
module tb_change_dispenser;

  localparam int AMT_W   = 10;
  localparam int STOCK_W = 8;
  localparam int T_ACK   = 255;
`ifdef CHANGE_STOCK_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic               clk, rst, req, coin_ack, refill_50, refill_100;
  logic [AMT_W-1:0]   amount;
  logic [1:0]         coin;
  logic               coin_valid, busy, done, short, fault;
  logic [AMT_W-1:0]   remaining;
  logic [STOCK_W-1:0] stock_50, stock_100;

  int checks = 0;
  int errors = 0;
  int s50m, s100m;
  logic [1:0] exp_q[$];

  change_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .amount     (amount),
    .coin       (coin),
    .coin_valid (coin_valid),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .remaining  (remaining),
    .fault      (fault),
    .refill_50  (refill_50),
    .refill_100 (refill_100),
    .stock_50   (stock_50),
    .stock_100  (stock_100)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_stock(input int m);
    return TRACK ? m : 255;
  endfunction

  function automatic int sat_inc(input int m);
    return (m >= 255) ? 255 : m + 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    s50m  = 20;
    s100m = 20;
  endtask

  task automatic check_reset_vals();
    chk("rst_coin", coin, 0);
    chk("rst_cv", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_s50", stock_50, exp_stock(20));
    chk("rst_s100", stock_100, exp_stock(20));
  endtask

  task automatic payout(input int amt, input int ack_dly, input bit refill_ack, input bit req_busy);
    int rem;
    int guard;
    bit got_done;
    bit first;
    logic [1:0] exp_coin;
    rem = amt;
    exp_q.delete();
    while (1) begin
      if (rem >= 100 && (!TRACK || s100m > 0)) begin
        exp_q.push_back(2'b10);
        rem -= 100;
        if (TRACK) s100m--;
      end else if (rem >= 50 && (!TRACK || s50m > 0)) begin
        exp_q.push_back(2'b01);
        rem -= 50;
        if (TRACK) s50m--;
      end else begin
        break;
      end
    end

    req = 1'b1;
    amount = AMT_W'(amt);
    @(negedge clk);
    req = 1'b0;
    chk("busy_select", busy, 1);
    chk("cv_select", coin_valid, 0);
    @(negedge clk);
    if (exp_q.size() > 0) chk("cv_req_n2", coin_valid, 1);

    first = 1'b1;
    got_done = 1'b0;
    guard = 0;
    while (!got_done && guard < 200) begin
      guard++;
      if (done) begin
        got_done = 1'b1;
      end else if (coin_valid) begin
        if (exp_q.size() == 0) exp_coin = 2'b00;
        else exp_coin = exp_q.pop_front();
        chk("coin", coin, exp_coin);
        if (req_busy && first) begin
          req = 1'b1;
          amount = 10'd500;
          @(negedge clk);
          req = 1'b0;
          amount = '0;
        end
        first = 1'b0;
        repeat (ack_dly) @(negedge clk);
        coin_ack = 1'b1;
        if (refill_ack && exp_coin == 2'b10) begin
          refill_100 = 1'b1;
          s100m = sat_inc(s100m);
        end
        @(negedge clk);
        coin_ack = 1'b0;
        refill_100 = 1'b0;
        chk("cv_after_ack", coin_valid, 0);
        if (exp_q.size() == 0) chk("done_after_last_ack", done, 1);
      end else begin
        @(negedge clk);
      end
    end
    chk("done_seen", got_done, 1);
    chk("rem_at_done", remaining, rem);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("short", short, rem != 0);
    chk("busy_end", busy, 0);
    chk("coins_left", exp_q.size(), 0);
    chk("stock_100", stock_100, exp_stock(s100m));
    chk("stock_50", stock_50, exp_stock(s50m));
  endtask

  initial begin
    int n;
    req = 1'b0;
    amount = '0;
    coin_ack = 1'b0;
    refill_50 = 1'b0;
    refill_100 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    check_reset_vals();

    // Greedy payouts: full stock, residue, zero, then draining 1 TL stock.
    payout(250, 0, 1'b0, 1'b0);
    payout(120, 1, 1'b0, 1'b0);
    payout(0, 0, 1'b0, 1'b0);
    payout(1000, 2, 1'b0, 1'b0);
    payout(600, 0, 1'b0, 1'b0);
    payout(250, 0, 1'b0, 1'b0);

    // Refills, then a refill coinciding with an ack of a 1 TL coin.
    repeat (2) begin
      refill_100 = 1'b1;
      @(negedge clk);
      refill_100 = 1'b0;
      s100m = TRACK ? sat_inc(s100m) : s100m;
      @(negedge clk);
    end
    chk("stock_100_refill", stock_100, exp_stock(s100m));
    payout(100, 0, 1'b1, 1'b0);

    // 50 kurus stock saturates at all-ones.
    for (int i = 0; i < 260; i++) begin
      refill_50 = 1'b1;
      @(negedge clk);
      s50m = sat_inc(s50m);
    end
    refill_50 = 1'b0;
    @(negedge clk);
    chk("stock_50_sat", stock_50, 255);

    // Reset while a 1 TL coin is presented.
    req = 1'b1;
    amount = 10'd100;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("pre_rst_cv", coin_valid, 1);
    chk("pre_rst_coin", coin, 2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    s50m = 20;
    s100m = 20;

    // A req while busy must not start a second payout.
    payout(100, 1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("no_second_busy", busy, 0);
    chk("no_second_cv", coin_valid, 0);
    chk("no_second_rem", remaining, 0);

    // Ack timeout.
    req = 1'b1;
    amount = 10'd100;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    n = 0;
    while (coin_valid && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk("cv_hold_cycles", n, T_ACK);
    chk("fault_set", fault, 1);
    chk("fault_cv", coin_valid, 0);
    chk("fault_busy", busy, 1);
    chk("fault_rem", remaining, 100);
    req = 1'b1;
    amount = 10'd50;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("fault_sticky", fault, 1);
    chk("fault_req_ign_cv", coin_valid, 0);
    chk("fault_req_ign_rem", remaining, 100);
    do_reset();
    check_reset_vals();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
